// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester IDs
// and default bus widths.
package dm_arb_pkg;

  localparam int AW = 12;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_LDR  = 1'b1
  } req_id_t;

endpackage

// File: rtl/dm_arb_prio.sv
// Winner select for the DM arbiter: core has fixed priority, the loader is
// forced through once it has lost STARVE_MAX arbitrations in a row.
module dm_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic l_req,
  input  logic arb,
  input  logic grant,
  output logic winner
);
  import dm_arb_pkg::*;

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    winner = REQ_CORE;
    if (l_req && (starved || !c_req)) winner = REQ_LDR;
  end

  // grant is the loader's grant pulse; it only occurs in ACCESS, so it never
  // coincides with an arbitration cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (grant)
      starve_cnt <= '0;
    else if (arb && l_req && winner == REQ_CORE && !starved)
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the CPU core and the loader/debug
// port: serialises accesses, drives the DM pins and returns registered rdata.
module dm_arbiter #(
  parameter int AW         = dm_arb_pkg::AW,
  parameter int DW         = dm_arb_pkg::DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          DM_enable_mem,
  output logic          DM_enable_fetch,
  output logic          DM_enable_write,
  output logic [AW-1:0] DM_in_address,
  output logic [AW-1:0] DM_out_address,
  output logic [DW-1:0] DM_in,
  input  logic [DW-1:0] DM_out,
  output logic          busy
);
  import dm_arb_pkg::*;

  state_t        state, state_nxt;
  logic          arb, winner, win_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, c_rdata_q, l_rdata_q;

  assign arb = (state == ST_IDLE || state == ST_RESP) && (c_req || l_req);

  dm_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .c_req  (c_req),
    .l_req  (l_req),
    .arb    (arb),
    .grant  (l_gnt),
    .winner (winner)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_RESP: state_nxt = arb ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:        state_nxt = we_q ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT:        state_nxt = ST_RESP;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      win_q     <= REQ_CORE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (arb) begin
        win_q   <= winner;
        we_q    <= (winner == REQ_LDR) ? l_we    : c_we;
        addr_q  <= (winner == REQ_LDR) ? l_addr  : c_addr;
        wdata_q <= (winner == REQ_LDR) ? l_wdata : c_wdata;
      end
      // DM_out is valid the cycle after the fetch, i.e. during RDWAIT.
      if (state == ST_RDWAIT) begin
        if (win_q == REQ_LDR) l_rdata_q <= DM_out;
        else                  c_rdata_q <= DM_out;
      end
    end
  end

  always_comb begin
    c_gnt           = 1'b0;
    l_gnt           = 1'b0;
    c_rvalid        = 1'b0;
    l_rvalid        = 1'b0;
    DM_enable_mem   = 1'b0;
    DM_enable_fetch = 1'b0;
    DM_enable_write = 1'b0;
    DM_in_address   = '0;
    DM_out_address  = '0;
    DM_in           = '0;
    if (state == ST_ACCESS) begin
      DM_enable_mem = 1'b1;
      c_gnt         = (win_q == REQ_CORE);
      l_gnt         = (win_q == REQ_LDR);
      if (we_q) begin
        DM_enable_write = 1'b1;
        DM_in_address   = addr_q;
        DM_in           = wdata_q;
      end else begin
        DM_enable_fetch = 1'b1;
        DM_out_address  = addr_q;
      end
    end
    if (state == ST_RESP) begin
      c_rvalid = (win_q == REQ_CORE);
      l_rvalid = (win_q == REQ_LDR);
    end
  end

  assign c_rdata = c_rdata_q;
  assign l_rdata = l_rdata_q;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level arbitration/memory model.
module tb_dm_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          DM_enable_mem, DM_enable_fetch, DM_enable_write, busy;
  logic [AW-1:0] DM_in_address, DM_out_address;
  logic [DW-1:0] DM_in;
  logic [DW-1:0] DM_out = '0;

  int n_tests = 0;
  int n_fail  = 0;

  dm_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .DM_enable_mem(DM_enable_mem), .DM_enable_fetch(DM_enable_fetch),
    .DM_enable_write(DM_enable_write), .DM_in_address(DM_in_address),
    .DM_out_address(DM_out_address), .DM_in(DM_in), .DM_out(DM_out),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  logic any_out;
  assign any_out = |{c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
                     DM_enable_mem, DM_enable_fetch, DM_enable_write,
                     DM_in_address, DM_out_address, DM_in, busy};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 'h010) return 32'hDEAD_BEEF;
    return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
  endfunction

  // DM behavioural model: one-cycle read latency, write at the clock edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (DM_enable_write) mem[DM_in_address] <= DM_in;
      if (DM_enable_fetch) DM_out <= mem[DM_out_address];
    end
  end

  // Reference model: arbitration outcome from the priority/starvation rules,
  // access timing from the per-transaction latencies, memory as an array.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int cyc, next_arb, busy_end, losses, c_due, l_due, c_rv_at, l_rv_at;
  logic [DW-1:0] c_exp, l_exp, c_hold, l_hold, w_wd;
  logic [AW-1:0] p_c_addr, p_l_addr, w_addr;
  logic [DW-1:0] p_c_wd, p_l_wd;
  logic p_c_req, p_l_req, p_c_we, p_l_we, exp_g, pred_l, w_we, last_c_gnt, last_l_gnt;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    c_rv_at = -1; l_rv_at = -1;
    forever begin
      @(negedge clk);
      last_c_gnt = c_gnt;
      last_l_gnt = l_gnt;
      if (!rst) begin
        cyc = 0; next_arb = 0; busy_end = -1; losses = 0;
        c_due = -1; l_due = -1; c_hold = '0; l_hold = '0;
        p_c_req = 1'b0; p_l_req = 1'b0;
        chk("rst_outs", any_out, 0);
      end else begin
        cyc++;
        exp_g  = (cyc - 1 >= next_arb) && (p_c_req || p_l_req);
        pred_l = p_l_req && (losses == SM || !p_c_req);
        w_we   = pred_l ? p_l_we   : p_c_we;
        w_addr = pred_l ? p_l_addr : p_c_addr;
        w_wd   = pred_l ? p_l_wd   : p_c_wd;
        chk("c_gnt",  c_gnt, exp_g && !pred_l);
        chk("l_gnt",  l_gnt, exp_g && pred_l);
        chk("mem_en", DM_enable_mem, exp_g);
        chk("fetch",  DM_enable_fetch, exp_g && !w_we);
        chk("write",  DM_enable_write, exp_g && w_we);
        if (exp_g) begin
          chk("rd_addr", DM_out_address, w_we ? '0 : w_addr);
          chk("wr_addr", DM_in_address,  w_we ? w_addr : '0);
          chk("wr_data", DM_in,          w_we ? w_wd : '0);
          if (pred_l) losses = 0;
          else if (p_l_req && losses < SM) losses++;
          next_arb = cyc + (w_we ? 1 : 2);
          busy_end = cyc + (w_we ? 0 : 2);
          if (w_we) ref_mem[w_addr] = w_wd;
          else if (pred_l) begin l_due = cyc + 2; l_exp = ref_mem[w_addr]; end
          else begin c_due = cyc + 2; c_exp = ref_mem[w_addr]; end
        end
        chk("busy", busy, cyc <= busy_end);
        chk("c_rvalid", c_rvalid, cyc == c_due);
        if (cyc == c_due) begin c_hold = c_exp; c_rv_at = cyc; end
        chk("c_rdata", c_rdata, c_hold);
        chk("l_rvalid", l_rvalid, cyc == l_due);
        if (cyc == l_due) begin l_hold = l_exp; l_rv_at = cyc; end
        chk("l_rdata", l_rdata, l_hold);
        p_c_req = c_req; p_c_we = c_we; p_c_addr = c_addr; p_c_wd = c_wdata;
        p_l_req = l_req; p_l_we = l_we; p_l_addr = l_addr; p_l_wd = l_wdata;
      end
    end
  end

  // which: 0 c_gnt, 1 l_gnt, 2 c_rvalid, 3 l_rvalid. Returns the model cycle.
  task automatic wait_for(input int which, input string tag, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < 30 && at < 0; i++) begin
      @(negedge clk); #1;
      case (which)
        0: s = c_gnt;
        1: s = l_gnt;
        2: s = c_rvalid;
        default: s = l_rvalid;
      endcase
      if (s) at = cyc;
    end
    if (at < 0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, g1, g2, rv, ncore;
  logic got;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Core read of the preloaded word
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; t0 = cyc + 1;
    wait_for(0, "rd_gnt", g1);
    chk("rd_gnt_lat", g1 - t0, 1);
    chk("rd_fetch", DM_enable_fetch, 1);
    chk("rd_oaddr", DM_out_address, 12'h010);
    @(posedge clk); #1 c_req = 1'b0;
    wait_for(2, "rd_rv", rv);
    chk("rd_lat", rv - t0, 3);
    chk("rd_data", c_rdata, 32'hDEAD_BEEF);
    chk("rd_l_rv", l_rvalid, 0);
    idle(2);

    // Loader write then read-back
    l_req = 1'b1; l_we = 1'b1; l_addr = 12'h020; l_wdata = 32'h1234_5678; t0 = cyc + 1;
    wait_for(1, "wr_gnt", g1);
    chk("wr_gnt_lat", g1 - t0, 1);
    chk("wr_strobe", DM_enable_write, 1);
    chk("wr_iaddr", DM_in_address, 12'h020);
    chk("wr_din", DM_in, 32'h1234_5678);
    @(posedge clk); #1 l_we = 1'b0;
    wait_for(1, "lrd_gnt", g1);
    @(posedge clk); #1 l_req = 1'b0;
    wait_for(3, "lrd_rv", rv);
    chk("lrd_data", l_rdata, 32'h1234_5678);
    idle(2);

    // Simultaneous reads: core first, loader in the next ACCESS
    c_req = 1'b1; c_addr = 12'h030; l_req = 1'b1; l_addr = 12'h020;
    wait_for(0, "both_cg", g1);
    @(posedge clk); #1 c_req = 1'b0;
    wait_for(1, "both_lg", g2);
    chk("both_gap", g2 - g1, 3);
    @(posedge clk); #1 l_req = 1'b0;
    wait_for(3, "both_lrv", rv);
    chk("both_rv_gap", l_rv_at - c_rv_at, 3);
    idle(3);

    // Starvation: core holds its request, loader breaks through every SM+1
    c_req = 1'b1; c_addr = 12'h005; l_req = 1'b1; l_addr = 12'h006;
    for (int r = 0; r < 2; r++) begin
      ncore = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk); #1;
        if (c_gnt) ncore++;
        if (l_gnt) got = 1'b1;
      end
      chk("starve_wins", ncore, SM);
    end
    @(posedge clk); #1 c_req = 1'b0; l_req = 1'b0;
    idle(4);

    // Reset during RDWAIT aborts the read
    c_req = 1'b1; c_addr = 12'h040;
    wait_for(0, "rst_gnt", g1);
    @(posedge clk); #1 rst = 1'b0; c_req = 1'b0;
    #1 chk("rst_abort_outs", any_out, 0);
    chk("rst_abort_busy", busy, 0);
    idle(2);
    rst = 1'b1;
    idle(4);
    c_req = 1'b1; c_addr = 12'h010;
    wait_for(0, "post_rst_gnt", g1);
    @(posedge clk); #1 c_req = 1'b0;
    wait_for(2, "post_rst_rv", rv);
    chk("post_rst_data", c_rdata, 32'hDEAD_BEEF);
    idle(2);

    // Back-to-back core reads through RESP arbitration
    c_req = 1'b1; c_addr = 12'h001;
    wait_for(0, "b2b_g1", g1);
    @(posedge clk); #1 c_addr = 12'h002;
    wait_for(0, "b2b_g2", g2);
    chk("b2b_gap", g2 - g1, 3);
    @(posedge clk); #1 c_req = 1'b0;
    wait_for(2, "b2b_rv", rv);
    chk("b2b_data", c_rdata, init_val(2));
    idle(3);

    // Random traffic, each requester holds until granted
    for (int k = 0; k < 3000; k++) begin
      if (!c_req || last_c_gnt) begin
        c_req = ($urandom_range(0, 99) < 60);
        c_we = 1'($urandom_range(0, 1));
        c_addr = 12'($urandom_range(0, 31));
        c_wdata = $urandom;
      end
      if (!l_req || last_l_gnt) begin
        l_req = ($urandom_range(0, 99) < 50);
        l_we = 1'($urandom_range(0, 1));
        l_addr = 12'($urandom_range(0, 31));
        l_wdata = $urandom;
      end
      idle(1);
    end
    c_req = 1'b0; l_req = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
